// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch-type encoding,
// RV32 control-flow opcodes and the link-register test used for call/return detection.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    BR_DIRECT   = 2'b00,
    BR_CALL     = 2'b01,
    BR_RETURN   = 2'b10,
    BR_INDIRECT = 2'b11
  } br_type_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // x1 (ra) and x5 (t0) are the RISC-V link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// Circular prediction queue: push at tail, pop at head, flush empties it.
// Flush wins over push/pop in the same cycle.
module bp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches in-order branch resolutions against queued fetch predictions and
// produces registered predictor-training pulses plus a mispredict redirect.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BHR_W = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_pc,
  input  logic                     enq_pred_taken,
  input  logic [31:0]              enq_pred_target,
  input  logic [BHR_W-1:0]         enq_bhr,
  input  logic                     res_valid,
  input  logic [31:0]              res_pc,
  input  logic [31:0]              res_inst,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     bht_update_en,
  output logic                     btb_update_en,
  output logic                     tc_update_en,
  output logic [31:0]              update_pc,
  output logic [31:0]              update_BTA,
  output logic [1:0]               update_type,
  output logic [BHR_W-1:0]         update_BHR,
  output logic                     branch_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow,
  output logic                     err_order
);
  localparam int EW = 65 + BHR_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]    head;
  logic [31:0]      head_pc;
  logic             head_taken;
  logic [31:0]      head_target;
  logic [BHR_W-1:0] head_bhr;
  logic             has_entry;
  logic             do_pop;
  logic             do_push;
  logic             mispredict;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic             is_valid;
  logic             is_cond;
  br_type_e         br_type;
  logic             unused_inst_bits;

  assign {head_pc, head_taken, head_target, head_bhr} = head;
  assign op  = res_inst[6:0];
  assign rd  = res_inst[11:7];
  assign rs1 = res_inst[19:15];
  assign unused_inst_bits = ^{res_inst[31:20], res_inst[14:12]};

  // Ready comes from occupancy alone, so a full queue refuses a push even while popping.
  assign enq_ready  = (count != CW'(DEPTH));
  assign has_entry  = (count != '0);
  assign do_pop     = res_valid & has_entry;
  assign mispredict = do_pop & ((res_taken != head_taken) |
                                (res_taken & head_taken & (res_target != head_target)));
  assign do_push    = enq_valid & enq_ready & ~mispredict;

  bp_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (do_push),
    .pop    (do_pop),
    .flush  (mispredict),
    .wdata  ({enq_pc, enq_pred_taken, enq_pred_target, enq_bhr}),
    .rdata  (head),
    .count  (count)
  );

  always_comb begin
    is_valid = 1'b1;
    is_cond  = 1'b0;
    br_type  = BR_DIRECT;
    case (op)
      OP_BRANCH: is_cond = 1'b1;
      OP_JAL:    if (is_link(rd)) br_type = BR_CALL;
      OP_JALR: begin
        if (is_link(rd))                        br_type = BR_CALL;
        else if ((rd == 5'd0) && is_link(rs1))  br_type = BR_RETURN;
        else                                    br_type = BR_INDIRECT;
      end
      default:   is_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      bht_update_en  <= 1'b0;
      btb_update_en  <= 1'b0;
      tc_update_en   <= 1'b0;
      update_pc      <= '0;
      update_BTA     <= '0;
      update_type    <= '0;
      update_BHR     <= '0;
      branch_en      <= 1'b0;
      err_underflow  <= 1'b0;
      err_order      <= 1'b0;
    end else begin
      redirect_valid <= mispredict;
      bht_update_en  <= do_pop & is_valid & is_cond;
      btb_update_en  <= do_pop & is_valid & res_taken;
      tc_update_en   <= do_pop & is_valid & (br_type == BR_INDIRECT) & res_taken;
      if (mispredict) redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
      // Training fields hold between pops; only the enables pulse.
      if (do_pop) begin
        update_pc   <= res_pc;
        update_BTA  <= res_target;
        update_type <= br_type;
        update_BHR  <= head_bhr;
        branch_en   <= res_taken;
      end
      if (res_valid && !has_entry) err_underflow <= 1'b1;
      if (do_pop && ((res_pc != head_pc) || !is_valid)) err_order <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, directed corner
// sequences and a random run against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 8;
  localparam int BHR_W = 10;
  localparam int K_COND = 0, K_CALL = 1, K_RET = 2, K_IND = 3, K_JAL = 4, K_INV = 5;

  logic clk = 1'b0;
  logic resetn;
  logic enq_valid, enq_ready, enq_pred_taken;
  logic [31:0] enq_pc, enq_pred_target;
  logic [BHR_W-1:0] enq_bhr;
  logic res_valid, res_taken;
  logic [31:0] res_pc, res_inst, res_target;
  logic redirect_valid, bht_update_en, btb_update_en, tc_update_en, branch_en;
  logic [31:0] redirect_pc, update_pc, update_BTA;
  logic [1:0] update_type;
  logic [BHR_W-1:0] update_BHR;
  logic [$clog2(DEPTH):0] count;
  logic err_underflow, err_order;

  branch_resolve_unit #(.DEPTH(DEPTH), .BHR_W(BHR_W)) dut (
    .clk(clk), .resetn(resetn),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target), .enq_bhr(enq_bhr),
    .res_valid(res_valid), .res_pc(res_pc), .res_inst(res_inst),
    .res_taken(res_taken), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bht_update_en(bht_update_en), .btb_update_en(btb_update_en), .tc_update_en(tc_update_en),
    .update_pc(update_pc), .update_BTA(update_BTA), .update_type(update_type),
    .update_BHR(update_BHR), .branch_en(branch_en), .count(count),
    .err_underflow(err_underflow), .err_order(err_order)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    logic [BHR_W-1:0] bhr;
  } pred_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        pt;
    logic [31:0] ptg;
    logic        rt;
    logic [31:0] rtg;
    logic [1:0]  exp_type;
    logic        exp_bht;
    logic        exp_btb;
    logic        exp_tc;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  pred_t mq[$];
  logic exp_uf, exp_ord;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enq_valid = 0; enq_pc = 0; enq_pred_taken = 0; enq_pred_target = 0; enq_bhr = 0;
    res_valid = 0; res_pc = 0; res_inst = 0; res_taken = 0; res_target = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_en", {bht_update_en, btb_update_en, tc_update_en, branch_en}, 0);
    check("rst_update_pc", update_pc, 0);
    check("rst_update_bta", update_BTA, 0);
    check("rst_update_type_bhr", {update_type, update_BHR}, 0);
    check("rst_errs", {err_underflow, err_order}, 0);
    resetn = 1;
    mq.delete();
    exp_uf = 0;
    exp_ord = 0;
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    logic [31:0] r;
    r = $urandom;
    return {r[31:20], rs1, r[14:12], rd, op};
  endfunction

  function automatic logic [4:0] pick_link();
    return ($urandom_range(0, 1) == 0) ? 5'd1 : 5'd5;
  endfunction

  function automatic logic [4:0] pick_nonlink(input logic allow_zero);
    logic [4:0] r;
    do r = 5'($urandom_range(0, 31));
    while (r == 5'd1 || r == 5'd5 || (!allow_zero && r == 5'd0));
    return r;
  endfunction

  // Builds an instruction word belonging to the requested class.
  function automatic logic [31:0] gen_inst(input int kind);
    logic [31:0] r;
    logic [4:0]  rd;
    r = $urandom;
    case (kind)
      K_COND: return {r[31:7], 7'b1100011};
      K_CALL: return ($urandom_range(0, 1) == 0) ? mk_inst(7'b1101111, pick_link(), r[19:15])
                                                 : mk_inst(7'b1100111, pick_link(), r[19:15]);
      K_RET:  return mk_inst(7'b1100111, 5'd0, pick_link());
      K_IND: begin
        rd = pick_nonlink(1'b1);
        return (rd == 5'd0) ? mk_inst(7'b1100111, rd, pick_nonlink(1'b1))
                            : mk_inst(7'b1100111, rd, r[19:15]);
      end
      K_JAL:  return mk_inst(7'b1101111, pick_nonlink(1'b1), r[19:15]);
      default: return {r[31:7], 7'b0010011};
    endcase
  endfunction

  function automatic logic [1:0] kind_type(input int kind);
    case (kind)
      K_CALL: return 2'b01;
      K_RET:  return 2'b10;
      K_IND:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // One clock of stimulus, checked against the queue model.
  task automatic model_cycle(input logic ev, input pred_t e, input logic rv, input logic [31:0] rpc,
                             input logic [31:0] rinst, input logic rtk, input logic [31:0] rtg,
                             input int kind);
    logic exp_ready, pop, mis, push;
    pred_t h;
    exp_ready = (mq.size() != DEPTH);
    check("enq_ready", enq_ready, exp_ready);
    pop = rv && (mq.size() != 0);
    h = '{default: '0};
    if (pop) h = mq[0];
    mis = pop && ((rtk != h.taken) || (rtk && h.taken && rtg != h.target));
    push = ev && exp_ready && !mis;
    enq_valid = ev; enq_pc = e.pc; enq_pred_taken = e.taken; enq_pred_target = e.target; enq_bhr = e.bhr;
    res_valid = rv; res_pc = rpc; res_inst = rinst; res_taken = rtk; res_target = rtg;
    tick();
    clear_inputs();
    check("redirect_valid", redirect_valid, mis);
    if (mis) check("redirect_pc", redirect_pc, rtk ? rtg : rpc + 32'd4);
    check("bht_update_en", bht_update_en, pop && kind == K_COND);
    check("btb_update_en", btb_update_en, pop && kind != K_INV && rtk);
    check("tc_update_en", tc_update_en, pop && kind == K_IND && rtk);
    if (pop) begin
      check("update_pc", update_pc, rpc);
      check("update_bta", update_BTA, rtg);
      check("update_bhr", update_BHR, h.bhr);
      check("branch_en", branch_en, rtk);
      if (kind != K_INV) check("update_type", update_type, kind_type(kind));
    end
    if (rv && !pop) exp_uf = 1;
    if (pop && (rpc != h.pc || kind == K_INV)) exp_ord = 1;
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    check("count", count, mq.size());
    check("err_underflow", err_underflow, exp_uf);
    check("err_order", err_order, exp_ord);
  endtask

  task automatic enq(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [BHR_W-1:0] bhr);
    pred_t e;
    e = '{pc: pc, taken: tk, target: tg, bhr: bhr};
    model_cycle(1'b1, e, 1'b0, 0, 0, 1'b0, 0, K_COND);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] inst, input logic tk,
                         input logic [31:0] tg, input int kind);
    pred_t e;
    e = '{default: '0};
    model_cycle(1'b0, e, 1'b1, pc, inst, tk, tg, kind);
  endtask

  task automatic idle();
    pred_t e;
    e = '{default: '0};
    model_cycle(1'b0, e, 1'b0, 0, 0, 1'b0, 0, K_COND);
  endtask

  vec_t vecs[11];

  initial begin
    pred_t e;
    clear_inputs();
    resetn = 0;
    exp_uf = 0;
    exp_ord = 0;
    do_reset();

    // Correct path: beq taken to the predicted target.
    enq(32'h100, 1'b1, 32'h200, 10'h3A5);
    check("cp_count1", count, 1);
    resolve(32'h100, 32'h00000063, 1'b1, 32'h200, K_COND);
    check("cp_bht", bht_update_en, 1);
    check("cp_btb", btb_update_en, 1);
    check("cp_noredir", redirect_valid, 0);
    check("cp_bhr", update_BHR, 10'h3A5);
    check("cp_count0", count, 0);
    idle();
    check("cp_pulse_end", {bht_update_en, btb_update_en}, 0);
    check("cp_hold_bhr", update_BHR, 10'h3A5);

    // Direction mispredict flushes three entries and drops a same-cycle enqueue.
    enq(32'h140, 1'b0, 32'h0, 10'h011);
    enq(32'h144, 1'b1, 32'h900, 10'h022);
    enq(32'h148, 1'b0, 32'h0, 10'h033);
    check("dm_count3", count, 3);
    e = '{pc: 32'h14C, taken: 1'b0, target: 0, bhr: 10'h044};
    model_cycle(1'b1, e, 1'b1, 32'h140, 32'h00001063, 1'b1, 32'h80, K_COND);
    check("dm_redir", redirect_valid, 1);
    check("dm_redir_pc", redirect_pc, 32'h80);
    check("dm_flushed", count, 0);
    idle();
    check("dm_pulse_end", redirect_valid, 0);

    // Not-taken mispredict at the top of the address space wraps to 0.
    enq(32'hFFFFFFFC, 1'b1, 32'h300, 10'h155);
    resolve(32'hFFFFFFFC, 32'h00004063, 1'b0, 32'h300, K_COND);
    check("nt_redir", redirect_valid, 1);
    check("nt_wrap_pc", redirect_pc, 32'h0);

    // Classification table: one prediction, one resolution, expected pulses.
    vecs[0]  = '{"beq_t",      32'h00000063, 1, 32'h2000, 1, 32'h2000, 2'b00, 1, 1, 0, 0, 32'h0};
    vecs[1]  = '{"beq_nt",     32'h00000063, 0, 32'h0,    0, 32'h2000, 2'b00, 1, 0, 0, 0, 32'h0};
    vecs[2]  = '{"jal_x1",     32'h000000EF, 1, 32'h3000, 1, 32'h3000, 2'b01, 0, 1, 0, 0, 32'h0};
    vecs[3]  = '{"jal_x0",     32'h0000006F, 1, 32'h3000, 1, 32'h3000, 2'b00, 0, 1, 0, 0, 32'h0};
    vecs[4]  = '{"jal_x5",     32'h000002EF, 1, 32'h3000, 1, 32'h3000, 2'b01, 0, 1, 0, 0, 32'h0};
    vecs[5]  = '{"ret_x1",     32'h00008067, 1, 32'h4000, 1, 32'h4000, 2'b10, 0, 1, 0, 0, 32'h0};
    vecs[6]  = '{"ret_x5",     32'h00028067, 1, 32'h4000, 1, 32'h4000, 2'b10, 0, 1, 0, 0, 32'h0};
    vecs[7]  = '{"ind_x6",     32'h00030067, 1, 32'h5000, 1, 32'h5004, 2'b11, 0, 1, 1, 1, 32'h5004};
    vecs[8]  = '{"call_jalr",  32'h000300E7, 1, 32'h5000, 1, 32'h5000, 2'b01, 0, 1, 0, 0, 32'h0};
    vecs[9]  = '{"ind_rd2",    32'h00008167, 1, 32'h6000, 1, 32'h6000, 2'b11, 0, 1, 1, 0, 32'h0};
    vecs[10] = '{"bne_tgtmis", 32'h00001063, 1, 32'h6000, 1, 32'h6008, 2'b00, 1, 1, 0, 1, 32'h6008};
    for (int i = 0; i < 11; i++) begin
      enq(32'h1000 + 32'(i * 4), vecs[i].pt, vecs[i].ptg, 10'(i + 1));
      res_valid = 1; res_pc = 32'h1000 + 32'(i * 4); res_inst = vecs[i].inst;
      res_taken = vecs[i].rt; res_target = vecs[i].rtg;
      tick();
      clear_inputs();
      mq.delete();
      check({vecs[i].name, "_type"}, update_type, vecs[i].exp_type);
      check({vecs[i].name, "_bht"}, bht_update_en, vecs[i].exp_bht);
      check({vecs[i].name, "_btb"}, btb_update_en, vecs[i].exp_btb);
      check({vecs[i].name, "_tc"}, tc_update_en, vecs[i].exp_tc);
      check({vecs[i].name, "_redir"}, redirect_valid, vecs[i].exp_redir);
      if (vecs[i].exp_redir) check({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].exp_rpc);
      check({vecs[i].name, "_bhr"}, update_BHR, 10'(i + 1));
      check({vecs[i].name, "_count"}, count, 0);
    end

    // Full queue, then steady enq+resolve across pointer wrap.
    for (int i = 0; i < DEPTH; i++) enq(32'h2000 + 32'(i * 4), 1'b1, 32'h8000 + 32'(i), 10'(i));
    check("full_count", count, DEPTH);
    check("full_not_ready", enq_ready, 0);
    for (int i = 0; i < 21; i++) begin
      e = '{pc: 32'h3000 + 32'(i * 4), taken: 1'b1, target: 32'h9000 + 32'(i), bhr: 10'(i + 100)};
      model_cycle(1'b1, e, 1'b1, mq[0].pc, 32'h00000063, 1'b1, mq[0].target, K_COND);
    end
    check("wrap_count", count, DEPTH - 1);
    while (mq.size() != 0) resolve(mq[0].pc, 32'h00000063, 1'b1, mq[0].target, K_COND);

    // Error flags: underflow, order mismatch, stickiness, reset clearing.
    resolve(32'h500, 32'h00000063, 1'b1, 32'h600, K_COND);
    check("uf_set", err_underflow, 1);
    check("uf_no_pulse", {bht_update_en, btb_update_en, redirect_valid}, 0);
    idle();
    check("uf_sticky", err_underflow, 1);
    enq(32'h500, 1'b1, 32'h600, 10'h2AA);
    resolve(32'h504, 32'h00000063, 1'b1, 32'h600, K_COND);
    check("ord_set", err_order, 1);
    check("ord_train_pc", update_pc, 32'h504);
    check("ord_bhr", update_BHR, 10'h2AA);
    do_reset();
    enq(32'h700, 1'b1, 32'h710, 10'h001);
    resolve(32'h700, 32'h00000013, 1'b1, 32'h710, K_INV);
    check("inv_order", err_order, 1);
    check("inv_no_en", {bht_update_en, btb_update_en, tc_update_en}, 0);

    // Reset mid-operation with a would-be mispredict in flight.
    do_reset();
    enq(32'h800, 1'b1, 32'h900, 10'h0F0);
    enq(32'h804, 1'b1, 32'h904, 10'h0F1);
    resetn = 0;
    res_valid = 1; res_pc = 32'h800; res_inst = 32'h00000063; res_taken = 0; res_target = 0;
    enq_valid = 1; enq_pc = 32'h808;
    tick();
    clear_inputs();
    check("rmid_no_redir", redirect_valid, 0);
    check("rmid_no_en", {bht_update_en, btb_update_en, tc_update_en}, 0);
    check("rmid_count", count, 0);
    do_reset();

    // Random traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      logic ev, rv, rtk;
      logic [31:0] rpc, rtg;
      int kind;
      e = '{pc: $urandom & 32'hFFFFFFFC, taken: 1'($urandom_range(0, 1)),
            target: $urandom & 32'hFFFFFFFC, bhr: 10'($urandom)};
      ev = ($urandom_range(0, 99) < 65);
      rv = ($urandom_range(0, 99) < 45);
      kind = $urandom_range(K_COND, K_JAL);
      if (mq.size() != 0) begin
        rpc = mq[0].pc;
        rtk = ($urandom_range(0, 99) < 85) ? mq[0].taken : ~mq[0].taken;
        rtg = ($urandom_range(0, 99) < 85) ? mq[0].target : ($urandom & 32'hFFFFFFFC);
      end else begin
        rpc = $urandom;
        rtk = 1'($urandom_range(0, 1));
        rtg = $urandom;
      end
      model_cycle(ev, e, rv, rpc, gen_inst(kind), rtk, rtg, kind);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
